phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
Master phase controller for the train route. It drives the 4-bit phase selector into the combinational sensor synchronizer and consumes that block's advance condition. It generates the dwell TIMER pulse the synchronizer muxes in phases 2-5, and decodes the current phase into motor, direction and track-switch commands. A watchdog latches a fault if the condition never arrives.

Parameters:
HOLD_CYCLES, 4, consecutive cycles cond must stay high before the phase advances (debounce); >=1
DWELL_CYCLES, 1000, cycles spent in a station phase (2-5) before timer asserts; >=1
WATCHDOG_CYCLES, 100000, maximum enabled cycles in WAIT before fault; must exceed DWELL_CYCLES+HOLD_CYCLES
CNT_W, 20, width of the dwell and watchdog counters; must hold WATCHDOG_CYCLES

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
enable  in  1  run permission; low pauses the route
clear  in  1  fault acknowledge; sampled only in FAULT
cond  in  1  advance condition returned by the synchronizer for the current selector
selector  out  4  current phase, drives the synchronizer Selector input
timer  out  1  dwell-elapsed flag, drives the synchronizer TIMER input
motor_en  out  1  traction enable
direction  out  1  0 = forward (phases 0-7), 1 = reverse (phases 8-15)
switch_a  out  1  high in phases 6-9
switch_b  out  1  high in phases 10-11
fault  out  1  watchdog fault latched
lap_count  out  8  completed route laps, mod 256

Behaviour:
- Synchronous reset, active-low (rst_n=0 at a rising edge of clk), dominates everything.
  - Reset values: state=IDLE, selector=0, timer=0, motor_en=0, fault=0, lap_count=0, all counters 0.
- States: IDLE, ARM, WAIT, ADVANCE, FAULT.
- IDLE:
  - Outputs are quiet (motor_en=0).
  - Goes to ARM when enable=1.
- ARM (exactly 1 cycle):
  - Clears the hold, dwell and watchdog counters, and clears timer.
  - Goes to WAIT unconditionally; an enable drop does not abort it.
  - Purpose: cond is combinational on selector, so the first cycle after a phase change is ignored.
- WAIT, enable=1:
  - Hold counter increments while cond=1 and clears to 0 when cond=0.
  - Hold counter reaching HOLD_CYCLES -> ADVANCE.
  - Watchdog counter increments every cycle; reaching WATCHDOG_CYCLES -> FAULT.
  - If hold and watchdog both reach terminal in the same cycle, ADVANCE wins.
- WAIT, enable=0:
  - All counters freeze, motor_en=0, no transitions.
  - Resumes in place when enable returns.
- Dwell timer:
  - Counts in WAIT, with enable=1, only when selector is 2-5.
  - timer is registered: it goes 1 on the cycle after the dwell count reaches DWELL_CYCLES.
  - Stays 1 until the next ARM.
- ADVANCE (exactly 1 cycle):
  - selector <= selector+1, with 15 wrapping to 0.
  - On the 15->0 wrap, lap_count <= lap_count+1 (255 wraps to 0).
  - Goes to ARM.
- Minimum phase length is 1 (ARM) + HOLD_CYCLES (WAIT) + 1 (ADVANCE) cycles.
- FAULT:
  - fault=1, motor_en=0, selector held.
  - clear=1 -> IDLE, fault=0, selector retained so a restart resumes the same phase.
  - enable has no effect in FAULT.
- motor_en = 1 only when state is WAIT, enable=1, and selector is not 2-5. It is 0 during station dwell.
- direction, switch_a and switch_b decode from selector in every state, including IDLE and FAULT.
- All outputs are registered or decoded from registered state only; there is no combinational path from cond to any output.

Test Plan:
Test parameters: HOLD_CYCLES=4, DWELL_CYCLES=20, WATCHDOG_CYCLES=100.
- Reset then enable=1 with cond=1 held -> selector steps 0->1 every 6 cycles; selector=0, motor_en=0 during reset.
- Phase 2, cond tied to timer (loopback) -> timer rises 21 cycles after WAIT entry, and selector=3 follows 4 cycles after cond first samples high plus 1 ADVANCE cycle; motor_en=0 throughout.
- cond glitch pattern 1,1,1,0,1,1,1,1 in WAIT -> no advance on the first burst; advance after the 4-high run.
- cond=0 in phase 7 -> fault=1 after 100 WAIT cycles with selector=7 held; clear=1 -> IDLE, fault=0; enable -> ARM at phase 7.
- Run 16 phases from selector 0 with cond=1 -> selector wraps 15->0 and lap_count 0->1; direction=1 exactly in phases 8-15; switch_a=1 in 6-9, switch_b=1 in 10-11.
- enable=0 for 10 cycles mid-dwell at count 8, then reasserted -> dwell completes at count 20 (paused cycles not counted); rst_n=0 mid-WAIT -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/phase_sequencer.sv
// Master phase controller for the train route. It steps a 4-bit phase selector
// that drives the sensor synchronizer, and advances only after that block's
// advance condition has been debounced. It also produces the station dwell
// timer, decodes the traction and track commands from the phase, and latches a
// watchdog fault when the advance condition never arrives.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | route stopped, waiting for enable
// ARM     | one settling cycle after a phase change; clears counters and timer
// WAIT    | debounce cond, run dwell and watchdog counters (frozen while !enable)
// ADVANCE | one cycle: step selector, count a lap on the 15 -> 0 wrap
// FAULT   | watchdog expired; selector held until clear
module phase_sequencer #(
  parameter int HOLD_CYCLES     = 4,
  parameter int DWELL_CYCLES    = 1000,
  parameter int WATCHDOG_CYCLES = 100000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic       cond,
  output logic [3:0] selector,
  output logic       timer,
  output logic       motor_en,
  output logic       direction,
  output logic       switch_a,
  output logic       switch_b,
  output logic       fault,
  output logic [7:0] lap_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_TC  = HOLD_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  DWELL_TC = CNT_W'(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]  WDOG_TC  = CNT_W'(WATCHDOG_CYCLES);

  typedef enum logic [2:0] {IDLE, ARM, WAIT, ADVANCE, FAULT} phaseState;

  phaseState         state;
  logic [HOLD_W-1:0] holdCnt;
  logic [HOLD_W-1:0] holdInc;
  logic [CNT_W-1:0]  dwellCnt;
  logic [CNT_W-1:0]  wdCnt;
  logic [CNT_W-1:0]  wdInc;
  logic              stationPhase;

  // Next-count values used for the terminal compares, so a terminal count
  // acts on the same cycle the counter reaches it.
  assign holdInc = holdCnt + 1'b1;
  assign wdInc   = wdCnt + 1'b1;

  // Phases 2-5 are station stops: dwell counts and traction is off.
  assign stationPhase = (selector >= 4'd2) && (selector <= 4'd5);

  // Track commands are pure decodes of the registered selector.
  assign direction = selector[3];
  assign switch_a  = (selector >= 4'd6) && (selector <= 4'd9);
  assign switch_b  = (selector[3:1] == 3'b101);

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      selector  <= '0;
      timer     <= 1'b0;
      motor_en  <= 1'b0;
      fault     <= 1'b0;
      lap_count <= '0;
      holdCnt   <= '0;
      dwellCnt  <= '0;
      wdCnt     <= '0;
    end else begin
      // Dwell terminal is registered one cycle late; ARM below overrides it.
      if (dwellCnt == DWELL_TC) timer <= 1'b1;

      case (state)
        IDLE: begin
          motor_en <= 1'b0;
          if (enable) state <= ARM;
        end

        ARM: begin
          holdCnt  <= '0;
          dwellCnt <= '0;
          wdCnt    <= '0;
          timer    <= 1'b0;
          motor_en <= enable && !stationPhase;
          state    <= WAIT;
        end

        WAIT: begin
          if (enable) begin
            if (stationPhase && (dwellCnt != DWELL_TC)) dwellCnt <= dwellCnt + 1'b1;
            holdCnt <= cond ? holdInc : '0;
            wdCnt   <= wdInc;
            // Debounced advance takes priority over a simultaneous watchdog expiry.
            if (cond && (holdInc == HOLD_TC)) begin
              state    <= ADVANCE;
              motor_en <= 1'b0;
            end else if (wdInc == WDOG_TC) begin
              state    <= FAULT;
              fault    <= 1'b1;
              motor_en <= 1'b0;
            end else begin
              motor_en <= !stationPhase;
            end
          end else begin
            motor_en <= 1'b0;
          end
        end

        ADVANCE: begin
          selector <= selector + 1'b1;
          if (selector == 4'hF) lap_count <= lap_count + 1'b1;
          motor_en <= 1'b0;
          state    <= ARM;
        end

        FAULT: begin
          motor_en <= 1'b0;
          // Selector is kept so a restart resumes the faulted phase.
          if (clear) begin
            fault <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
